// File: rtl/bch_syndrome_calc.sv
// Bit-serial BCH syndrome generator over GF(2^13): computes S1..S2T of a received word, MSB first.
// Optional `BCH_SYND_ZERO_DETECT_EN adds a registered no_error flag alongside synd.
module bch_syndrome_calc #(
    parameter int T = 4,
    parameter int N = 8191
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    input  logic                din,
    output logic                din_ready,
    output logic [2*T*13-1:0]   synd,
    output logic                synd_valid,
    input  logic                synd_ready,
    output logic                overrun
`ifdef BCH_SYND_ZERO_DETECT_EN
    ,
    output logic                no_error
`endif
);
    localparam int M = 13;
    localparam int NS = 2 * T;
    localparam logic [M-1:0] LAST = M'(N - 1);
    localparam logic [M-1:0] POLY_LOW = 13'h001B;

    // Handshake: a bit transfers on din_valid & din_ready; a syndrome set transfers on
    // synd_valid & synd_ready. synd/synd_valid are held while valid and not ready.

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state;
    logic [M-1:0]           cnt;
    logic [NS-1:0][M-1:0]   acc;
    logic [NS-1:0][M-1:0]   acc_next;
    logic                   accept;
    logic                   frame_done;

    // Multiply by alpha^p for a constant p: unrolls into a fixed XOR network.
    function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] v, input int p);
        logic [M-1:0] r;
        r = v;
        for (int k = 0; k < p; k++) begin
            r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY_LOW : '0);
        end
        return r;
    endfunction

    assign din_ready  = 1'b1;
    assign accept     = din_valid & din_ready;
    assign frame_done = (cnt == LAST);

    // Horner step: in IDLE the accumulators are known zero, so start from zero.
    always_comb begin
        acc_next = '0;
        for (int j = 0; j < NS; j++) begin
            acc_next[j] = mul_alpha_pow((state == IDLE) ? '0 : acc[j], j + 1) ^ M'(din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            synd       <= '0;
            synd_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef BCH_SYND_ZERO_DETECT_EN
            no_error   <= 1'b0;
`endif
        end else begin
            if (synd_valid && synd_ready) begin
                synd_valid <= 1'b0;
            end
            if (accept) begin
                if (frame_done) begin
                    // A completing frame wins over the handshake and may overwrite unread results.
                    state      <= IDLE;
                    cnt        <= '0;
                    acc        <= '0;
                    synd       <= acc_next;
                    synd_valid <= 1'b1;
                    if (synd_valid && !synd_ready) begin
                        overrun <= 1'b1;
                    end
`ifdef BCH_SYND_ZERO_DETECT_EN
                    no_error   <= (acc_next == '0);
`endif
                end else begin
                    state <= ACCUM;
                    cnt   <= cnt + M'(1);
                    acc   <= acc_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_bch_syndrome_calc.sv
// Bench for bch_syndrome_calc: directed and randomized frames against a power-sum syndrome model.
// Build with +define+BCH_SYND_ZERO_DETECT_EN to also check no_error.
module tb_bch_syndrome_calc;
  localparam int T  = 4;
  localparam int N  = 127;
  localparam int SW = 2 * T * 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          din_valid;
  logic          din;
  logic          din_ready;
  logic [SW-1:0] synd;
  logic          synd_valid;
  logic          synd_ready;
  logic          overrun;
`ifdef BCH_SYND_ZERO_DETECT_EN
  logic          no_error;
`endif

  int            compared = 0;
  int            mismatched = 0;
  int            exp_tab[8191];
  logic [N-1:0]  frame;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] exp_s;
  logic [SW-1:0] all_ones;
  logic [SW-1:0] r1_synd;

  bch_syndrome_calc #(.T(T), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .synd       (synd),
    .synd_valid (synd_valid),
    .synd_ready (synd_ready),
    .overrun    (overrun)
`ifdef BCH_SYND_ZERO_DETECT_EN
    ,
    .no_error   (no_error)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // Sj = sum over set bits r[i] of alpha^(j*i), with alpha^k taken from a power table.
  function automatic logic [SW-1:0] model_synd(input logic [N-1:0] r);
    logic [SW-1:0] s;
    s = '0;
    for (int j = 1; j <= 2 * T; j++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) s[(j-1)*13 +: 13] = s[(j-1)*13 +: 13] ^ 13'(exp_tab[(j * i) % 8191]);
      end
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive frame r[N-1] first; idle cycles carry junk on din. Returns on the negedge after the last bit.
  task automatic send_frame(input int gap_pct, input bit rdy_last);
    for (int i = N - 1; i >= 0; i--) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        din_valid = 1'b0;
        din = 1'($urandom);
        @(negedge clk);
      end
      if (i == 0 && rdy_last) synd_ready = 1'b1;
      din_valid = 1'b1;
      din = frame[i];
      @(negedge clk);
    end
    din_valid = 1'b0;
    exp_q.push_back(model_synd(frame));
  endtask

  // Only the most recently completed frame is visible; older unread ones are overwritten.
  task automatic take_expected();
    exp_s = exp_q[$];
    exp_q.delete();
  endtask

  task automatic random_frame();
    for (int i = 0; i < N; i++) frame[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    exp_tab[0] = 1;
    for (int k = 1; k < 8191; k++) begin
      exp_tab[k] = exp_tab[k-1] << 1;
      if ((exp_tab[k] & 'h2000) != 0) exp_tab[k] = exp_tab[k] ^ 'h201B;
    end
    for (int j = 0; j < 2 * T; j++) begin
      all_ones[j*13 +: 13] = 13'h0001;
      r1_synd[j*13 +: 13]  = 13'(1 << (j + 1));
    end

    // reset
    rst = 1'b1; din_valid = 1'b0; din = 1'b0; synd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_synd_valid", SW'(synd_valid), '0);
    check("reset_synd", synd, '0);
    check("reset_overrun", SW'(overrun), '0);
    check("din_ready", SW'(din_ready), SW'(1));
    rst = 1'b0;

    // all-zero frame
    frame = '0;
    send_frame(0, 1'b0);
    take_expected();
    check("zero_valid", SW'(synd_valid), SW'(1));
    check("zero_synd", synd, '0);
    check("zero_model", exp_s, '0);
`ifdef BCH_SYND_ZERO_DETECT_EN
    check("zero_no_error", SW'(no_error), SW'(1));
`endif
    @(negedge clk);
    check("zero_valid_drop", SW'(synd_valid), '0);

    // only r[0]
    frame = '0; frame[0] = 1'b1;
    send_frame(0, 1'b0);
    take_expected();
    check("r0_synd", synd, all_ones);

    // only r[1]
    frame = '0; frame[1] = 1'b1;
    send_frame(0, 1'b0);
    take_expected();
    check("r1_synd", synd, r1_synd);
`ifdef BCH_SYND_ZERO_DETECT_EN
    check("r1_no_error", SW'(no_error), '0);
`endif

    // random frames with random din_valid gaps
    for (int f = 0; f < 4; f++) begin
      random_frame();
      send_frame(30, 1'b0);
      take_expected();
      check("rand_valid", SW'(synd_valid), SW'(1));
      check("rand_synd", synd, exp_s);
      @(negedge clk);
    end

    // only r[1] with din_valid toggled
    frame = '0; frame[1] = 1'b1;
    send_frame(50, 1'b0);
    take_expected();
    check("r1_gapped_synd", synd, r1_synd);
    @(negedge clk);

    // back-to-back frames while downstream stalls
    synd_ready = 1'b0;
    random_frame();
    send_frame(0, 1'b0);
    take_expected();
    check("b2b_first_synd", synd, exp_s);
    check("b2b_first_overrun", SW'(overrun), '0);
    random_frame();
    send_frame(0, 1'b0);
    take_expected();
    check("b2b_second_synd", synd, exp_s);
    check("b2b_overrun", SW'(overrun), SW'(1));
    check("b2b_valid", SW'(synd_valid), SW'(1));
    @(negedge clk);
    check("hold_synd", synd, exp_s);
    check("hold_valid", SW'(synd_valid), SW'(1));

    // handshake on the same edge a new frame completes: valid stays, synd reloads
    random_frame();
    send_frame(0, 1'b1);
    take_expected();
    check("same_edge_valid", SW'(synd_valid), SW'(1));
    check("same_edge_synd", synd, exp_s);
    @(negedge clk);
    check("same_edge_drop", SW'(synd_valid), '0);
    check("overrun_sticky", SW'(overrun), SW'(1));

    // reset mid-frame, with din_valid and synd_ready active during reset
    for (int i = 0; i < 100; i++) begin
      din_valid = 1'b1; din = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b1; din_valid = 1'b1; din = 1'b1; synd_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; synd_ready = 1'b1;
    check("midrst_valid", SW'(synd_valid), '0);
    check("midrst_synd", synd, '0);
    check("midrst_overrun", SW'(overrun), '0);
    frame = '0; frame[0] = 1'b1;
    send_frame(0, 1'b0);
    take_expected();
    check("midrst_r0_synd", synd, all_ones);
    check("midrst_r0_valid", SW'(synd_valid), SW'(1));
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bch_syndrome_calc.md
BCH_SYNDROME_CALC -- requirements
Module: bch_syndrome_calc

Interface
REQ-001 SHALL have parameter T, default 4: correction capability; 2T syndromes computed.
REQ-002 SHALL have parameter N, default 8191: codeword length in bits, 2T*13 < N <= 8191.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port din_valid, input, 1: din carries a codeword bit this cycle.
REQ-006 SHALL have port din, input, 1: codeword bit, highest-degree coefficient r[N-1] first.
REQ-007 SHALL have port din_ready, output, 1: block accepts a bit this cycle.
REQ-008 SHALL have port synd, output, 2T*13: S1 in bits [12:0], Sj in bits [13j-1:13(j-1)].
REQ-009 SHALL have port synd_valid, output, 1: synd holds a completed frame's syndromes.
REQ-010 SHALL have port synd_ready, input, 1: downstream key-equation solver accepts synd.
REQ-011 SHALL have port overrun, output, 1: sticky; a frame finished while synd was still pending.

Function
REQ-012 SHALL do all arithmetic in GF(2^13) with field polynomial x^13+x^4+x^3+x+1 and alpha = 0x0002.
REQ-013 SHALL keep 2T accumulators; on each accepted bit (din_valid & din_ready), Sj <= Sj*alpha^j XOR din, for j=1..2T.
REQ-014 SHALL implement each alpha^j product as a fixed combinational XOR matrix, with no generic multiplier.
REQ-015 SHALL count accepted bits with a 13-bit counter, 0..N-1; the bit at count N-1 completes the frame.
REQ-016 SHALL, on the completing bit, copy the final accumulator values (including that bit) into the synd register in the same edge, assert synd_valid next cycle, and clear accumulators and counter.
REQ-017 SHALL have a latency of 1 cycle from the last accepted bit to synd_valid=1.
REQ-018 SHALL let the next frame's first bit be accepted in the cycle immediately after the completing bit.
REQ-019 SHALL hold synd and synd_valid stable while synd_valid & ~synd_ready.
REQ-020 SHALL deassert synd_valid the cycle after synd_valid & synd_ready, unless a new frame completes on that same edge, in which case synd loads and synd_valid stays 1.
REQ-021 SHALL tie din_ready to 1; input is never back-pressured.
REQ-022 SHALL, if a frame completes while synd_valid=1 and synd_ready=0, overwrite synd with the new frame and set overrun=1.
REQ-023 SHALL ignore din when din_valid=0, changing neither accumulators nor counter.
REQ-024 SHALL have the state machine IDLE (count=0, no frame in progress), ACCUM (0<count<N) and DONE (synd_valid=1), with DONE being independent of IDLE/ACCUM.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set accumulators, counter, synd, synd_valid and overrun to 0.
REQ-026 SHALL, on reset mid-frame, discard the partial frame; the next accepted bit is treated as r[N-1].
REQ-027 SHALL give rst priority over din_valid and synd_ready in the same cycle.

Configuration
REQ-028 SHALL, with macro BCH_SYND_ZERO_DETECT_EN defined, add output no_error (1 bit), registered alongside synd: 1 when all 2T syndromes are zero, reset 0.
REQ-029 SHALL, without BCH_SYND_ZERO_DETECT_EN, omit the no_error port and its logic; all other behaviour is identical.

Verification
REQ-030 SHALL verify: N all-zero bits, synd_ready=1 -> synd_valid=1 for 1 cycle, every Sj=0x0000, no_error=1 if enabled.
REQ-031 SHALL verify: only the last bit (r[0]) =1 -> every Sj=0x0001.
REQ-032 SHALL verify: only r[1]=1 -> S1=0x0002, S2=0x0004, S3=0x0008, and no_error=0 if enabled.
REQ-033 SHALL verify: two back-to-back frames with din_valid held high and synd_ready=0 -> second synd overwrites first, overrun=1, synd_valid stays 1.
REQ-034 SHALL verify: rst pulse after 100 bits, then a full frame with only r[0]=1 -> every Sj=0x0001, with no contribution from the discarded bits.
REQ-035 SHALL verify: din_valid toggled randomly through a frame with only r[1]=1 -> same syndromes as REQ-032.
